// File: rtl/modadd_seq_pkg.sv
// modadd_seq shared definitions: widths, opcodes, FSM states.
// Optional range check enabled by MODSEQ_RANGE_CHECK_EN.
package modadd_seq_pkg;

  localparam int W    = 381;
  localparam int NREG = 8;
  localparam int AW   = $clog2(NREG);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_LOADM = 3'b011;
  localparam logic [2:0] OP_READ  = 3'b100;
  localparam logic [2:0] OP_DBL   = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/modadd_seq_modadder.sv
// modadder: modular add/subtract core, start-to-done pipeline.
// Stage 1 forms raw a+b / a-b, stage 2 folds it into [0, m).
module modadder #(
  parameter int W = 381
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_m,
  output logic [W-1:0] result,
  output logic         done
);

  logic         v1;
  logic         sub_q;
  logic [W:0]   raw;
  logic [W-1:0] m_q;
  logic [W-1:0] up;
  logic [W-1:0] dn;
  logic [W-1:0] nxt;

  // Low-bit wraparound is exact: the true result always fits below m.
  always_comb begin
    up  = raw[W-1:0] + m_q;
    dn  = raw[W-1:0] - m_q;
    nxt = raw[W-1:0];
    if (sub_q) begin
      if (raw[W]) nxt = up;
    end else if (raw >= {1'b0, m_q}) begin
      nxt = dn;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1     <= 1'b0;
      sub_q  <= 1'b0;
      raw    <= '0;
      m_q    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      v1   <= start;
      done <= v1;
      if (start) begin
        sub_q <= subtract;
        m_q   <= in_m;
        raw   <= subtract ? ({1'b0, in_a} - {1'b0, in_b})
                          : ({1'b0, in_a} + {1'b0, in_b});
      end
      if (v1) result <= nxt;
    end
  end

endmodule

// File: rtl/modadd_seq.sv
// modadd_seq: command sequencer around modadder with 8x381b regfile.
// MODSEQ_RANGE_CHECK_EN rejects operands not below the modulus.
module modadd_seq
  import modadd_seq_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srca,
  input  logic [AW-1:0] cmd_srcb,
  input  logic [W-1:0]  cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          busy,
  output logic          err
);

  state_t        state;
  logic [W-1:0]  rf [NREG];
  logic [W-1:0]  modulus;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          sub_q;
  logic [AW-1:0] dst_q;

  logic [W-1:0]  acc_a;
  logic [W-1:0]  acc_b;
  logic          is_arith;
  logic          range_bad;
  logic          core_start;
  logic          core_done;
  logic [W-1:0]  core_res;

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign rsp_valid  = (state == S_RESP);
  assign core_start = (state == S_ISSUE);

  assign acc_a    = rf[cmd_srca];
  assign acc_b    = (cmd_op == OP_DBL) ? rf[cmd_srca] : rf[cmd_srcb];
  assign is_arith = (cmd_op == OP_ADD) || (cmd_op == OP_SUB) ||
                    (cmd_op == OP_DBL);

`ifdef MODSEQ_RANGE_CHECK_EN
  assign range_bad = (acc_a >= modulus) || (acc_b >= modulus);
`else
  assign range_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      modulus  <= '0;
      op_a     <= '0;
      op_b     <= '0;
      sub_q    <= 1'b0;
      dst_q    <= '0;
      rsp_data <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            unique case (1'b1)
              cmd_op == OP_LOAD:  rf[cmd_dst] <= cmd_data;
              cmd_op == OP_LOADM: modulus <= cmd_data;
              cmd_op == OP_READ: begin
                rsp_data <= acc_a;
                state    <= S_RESP;
              end
              is_arith: begin
                if (range_bad) begin
                  err <= 1'b1;
                end else begin
                  op_a  <= acc_a;
                  op_b  <= acc_b;
                  sub_q <= (cmd_op == OP_SUB);
                  dst_q <= cmd_dst;
                  state <= S_ISSUE;
                end
              end
              default: err <= 1'b1;
            endcase
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            rf[dst_q] <= core_res;
            state     <= S_IDLE;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  modadder #(.W(W)) u_core (
    .clk      (clk),
    .resetn   (resetn),
    .start    (core_start),
    .subtract (sub_q),
    .in_a     (op_a),
    .in_b     (op_b),
    .in_m     (modulus),
    .result   (core_res),
    .done     (core_done)
  );

endmodule
